// File: rtl/trisc_mb_core.sv
// trisc_mb_core: multi-cycle MicroBlaze-subset CPU with a synchronous instruction ROM port,
// a req/ack data memory port and NPORT memory-mapped byte I/O ports.
module trisc_mb_core #(
    parameter int          PAW     = 12,
    parameter int          DAW     = 12,
    parameter int          NPORT   = 2,
    parameter logic [31:0] IO_BASE = 32'h0000_4000
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PAW-3:0]     imem_addr,
    input  logic [31:0]        imem_data,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DAW-1:0]     dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    input  logic               dmem_ack,
    input  logic [8*NPORT-1:0] in_port,
    output logic [8*NPORT-1:0] out_port,
    output logic               trap
);
    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    state_t             state_q, state_d;
    logic [PAW-1:0]     pc_q, pc_d, tgt_q, tgt_d;
    logic               c_q, c_d, li_q, li_d, dly_q, dly_d, we_q, we_d;
    logic [15:0]        ri_q, ri_d;
    logic [4:0]         ld_q, ld_d;
    logic [DAW-1:0]     addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [8*NPORT-1:0] out_q, out_d;
    logic [31:0]        rf_q [32];

    logic               rf_we;
    logic [4:0]         rf_wa;
    logic [31:0]        rf_wd;

    logic [5:0]         op;
    logic [4:0]         rd, ra_i, rb_i;
    logic [15:0]        imm16;
    logic [31:0]        ra, rb, rdv, imm32, opb, ea, kk, io_rd, cmp_v, res;
    logic [32:0]        sum;
    logic [PAW-1:0]     tgt;
    logic [2:0]         cc;
    logic               is_add, is_cmp, is_or, is_xor, is_ld, is_st, is_imm;
    logic               is_br, is_bcc, is_rtsd, is_bra, legal, io, zero, cond;
    logic               taken, delay, link, gt, wr;

    // Bit 0 of the MicroBlaze numbering is the MSB, so ir[k] lives at imem_data[31-k].
    always_comb begin
        op     = imem_data[31:26];
        rd     = imem_data[25:21];
        ra_i   = imem_data[20:16];
        rb_i   = imem_data[15:11];
        imm16  = imem_data[15:0];
        ra     = rf_q[ra_i];
        rb     = rf_q[rb_i];
        rdv    = rf_q[rd];
        imm32  = li_q ? {ri_q, imm16} : {{16{imm16[15]}}, imm16};
        opb    = op[3] ? imm32 : rb;
        sum    = {1'b0, ra} + {1'b0, opb} + {32'b0, op[1] & c_q};
        ea     = ra + opb;
        io     = ea >= IO_BASE;
        kk     = (ea - IO_BASE) >> 2;
        is_add  = op[5:4] == 2'b00 && !op[0];
        is_cmp  = op == 6'b000101;
        is_or   = {op[5:4], op[2:0]} == 5'b10000;
        is_xor  = {op[5:4], op[2:0]} == 5'b10010;
        is_ld   = {op[5:4], op[2:0]} == 5'b11010;
        is_st   = {op[5:4], op[2:0]} == 5'b11110;
        is_br   = {op[5:4], op[2:0]} == 5'b10110;
        is_bcc  = {op[5:4], op[2:0]} == 5'b10111;
        is_imm  = op == 6'b101100;
        is_rtsd = op == 6'b101101;
        is_bra  = is_br | is_bcc | is_rtsd;
        legal   = is_add | is_cmp | is_or | is_xor | is_ld | is_st | is_imm | is_bra;
        zero   = ra == 32'd0;
        cc     = imem_data[23:21];
        cond   = cc == 3'd0 ? zero :
                 cc == 3'd1 ? !zero :
                 cc == 3'd2 ? ra[31] :
                 cc == 3'd3 ? ra[31] | zero :
                 cc == 3'd4 ? !ra[31] && !zero :
                 cc == 3'd5 ? !ra[31] : 1'b0;
        taken  = is_br | is_rtsd | (is_bcc & cond);
        delay  = is_br ? imem_data[20] : imem_data[25];
        link   = is_br & imem_data[18];
        tgt    = PAW'(is_rtsd ? ra + imm32 : (is_br & imem_data[19]) ? opb : 32'(pc_q) + opb);
        gt     = imem_data[1] ? ra > rb : $signed(ra) > $signed(rb);
        cmp_v  = {gt, 31'(rb - ra)};
        io_rd  = 32'd0;
        for (int i = 0; i < NPORT; i++)
            if (kk == 32'(i)) io_rd = {24'd0, in_port[8*i +: 8]};
        res    = is_add ? sum[31:0] : is_cmp ? cmp_v : is_or ? ra | opb :
                 is_xor ? ra ^ opb : is_ld ? io_rd : 32'(pc_q);
        wr     = is_add | is_cmp | is_or | is_xor | (is_ld & io) | link;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        c_d     = c_q;
        li_d    = li_q;
        ri_d    = ri_q;
        dly_d   = dly_q;
        we_d    = we_q;
        ld_d    = ld_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        out_d   = out_q;
        rf_we   = 1'b0;
        rf_wa   = rd;
        rf_wd   = res;
        case (state_q)
            FETCH: state_d = EXEC;
            EXEC: begin
                if (!legal || (is_bra && dly_q)) begin
                    state_d = HALT;
                end else if ((is_ld || is_st) && !io) begin
                    state_d = MEM;
                    li_d    = 1'b0;
                    we_d    = is_st;
                    ld_d    = rd;
                    addr_d  = ea[DAW+1:2];
                    wdata_d = rdv;
                end else begin
                    state_d = FETCH;
                    li_d    = is_imm;
                    ri_d    = is_imm ? imm16 : ri_q;
                    rf_we   = wr && rd != 5'd0;
                    c_d     = (is_add && !op[2]) ? sum[32] : c_q;
                    for (int i = 0; i < NPORT; i++)
                        if (is_st && kk == 32'(i)) out_d[8*i +: 8] = rdv[7:0];
                    // A delayed branch runs the slot first, then jumps to the latched target.
                    if (taken && delay) begin
                        pc_d  = pc_q + PAW'(4);
                        tgt_d = tgt;
                        dly_d = 1'b1;
                    end else if (taken) begin
                        pc_d = tgt;
                    end else begin
                        pc_d  = dly_q ? tgt_q : pc_q + PAW'(4);
                        dly_d = 1'b0;
                    end
                end
            end
            MEM: begin
                if (dmem_ack) begin
                    state_d = FETCH;
                    rf_we   = !we_q && ld_q != 5'd0;
                    rf_wa   = ld_q;
                    rf_wd   = dmem_rdata;
                    pc_d    = dly_q ? tgt_q : pc_q + PAW'(4);
                    dly_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            tgt_q   <= '0;
            c_q     <= 1'b0;
            li_q    <= 1'b0;
            ri_q    <= '0;
            dly_q   <= 1'b0;
            we_q    <= 1'b0;
            ld_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            out_q   <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            c_q     <= c_d;
            li_q    <= li_d;
            ri_q    <= ri_d;
            dly_q   <= dly_d;
            we_q    <= we_d;
            ld_q    <= ld_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            out_q   <= out_d;
            if (rf_we) rf_q[rf_wa] <= rf_wd;
        end
    end

    assign imem_addr  = pc_q[PAW-1:2];
    assign dmem_req   = state_q == MEM;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign out_port   = out_q;
    assign trap       = state_q == HALT;
endmodule

// File: tb/tb_trisc_mb_core.sv
// tb_trisc_mb_core: directed programs for trisc_mb_core with hand-computed register,
// port, memory-handshake and trap expectations.
module tb_trisc_mb_core;
    localparam logic [5:0] ADD = 6'b000000, ADDC = 6'b000010, ADDI = 6'b001000, IMM = 6'b101100;
    localparam logic [5:0] SWI = 6'b111110, LWI = 6'b111010, BRI = 6'b101110;

    logic        clk = 1'b0, reset = 1'b0;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data = 32'd0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [11:0] dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata = 32'd0, mem_w;
    logic [15:0] in_port = 16'd0, out_port;
    logic        trap;
    logic [31:0] rom [1024];
    int          nvec = 0, nerr = 0;

    trisc_mb_core dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .in_port(in_port), .out_port(out_port),
        .trap(trap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) imem_data <= rom[imem_addr];

    function automatic logic [31:0] ti(input logic [5:0] op, input logic [4:0] d, input logic [4:0] a,
                                       input logic [15:0] im);
        return {op, d, a, im};
    endfunction

    function automatic logic [31:0] tr(input logic [5:0] op, input logic [4:0] d, input logic [4:0] a,
                                       input logic [4:0] b);
        return {op, d, a, b, 11'd0};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_rom();
        reset = 1'b0;
        #1;
        nvec++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL rst_req got=%b exp=0", dmem_req); end
        do_reset();
        #1;
        nvec++; if (imem_addr !== 10'd0) begin nerr++; $display("FAIL rst_pc got=%h exp=0", imem_addr); end
        nvec++; if (dmem_we !== 1'b0) begin nerr++; $display("FAIL rst_we got=%b exp=0", dmem_we); end
        nvec++; if (trap !== 1'b0) begin nerr++; $display("FAIL rst_trap got=%b exp=0", trap); end
        nvec++; if (out_port !== 16'd0) begin nerr++; $display("FAIL rst_out got=%h exp=0", out_port); end
    endtask

    task automatic test_add();
        clear_rom();
        rom[0] = ti(ADDI, 5'd1, 5'd0, 16'd5);
        rom[1] = ti(ADDI, 5'd2, 5'd0, 16'hFFFD);
        rom[2] = tr(ADD, 5'd3, 5'd1, 5'd2);
        rom[3] = tr(ADDC, 5'd8, 5'd0, 5'd0);
        rom[4] = ti(ADDI, 5'd0, 5'd0, 16'd9);
        do_reset();
        cyc(5);
        nvec++; if (dut.rf_q[3] !== 32'd0) begin nerr++; $display("FAIL add_early got=%h exp=0", dut.rf_q[3]); end
        cyc(1);
        nvec++; if (dut.rf_q[3] !== 32'd2) begin nerr++; $display("FAIL add_r3 got=%h exp=2", dut.rf_q[3]); end
        nvec++; if (dut.rf_q[1] !== 32'd5) begin nerr++; $display("FAIL add_r1 got=%h exp=5", dut.rf_q[1]); end
        nvec++; if (dut.rf_q[2] !== 32'hFFFF_FFFD) begin nerr++; $display("FAIL add_r2 got=%h exp=fffffffd", dut.rf_q[2]); end
        nvec++; if (imem_addr !== 10'd3) begin nerr++; $display("FAIL add_cpi got=%h exp=3", imem_addr); end
        cyc(2);
        nvec++; if (dut.rf_q[8] !== 32'd1) begin nerr++; $display("FAIL add_carry got=%h exp=1", dut.rf_q[8]); end
        cyc(2);
        nvec++; if (dut.rf_q[0] !== 32'd0) begin nerr++; $display("FAIL add_r0 got=%h exp=0", dut.rf_q[0]); end
    endtask

    task automatic test_imm();
        clear_rom();
        rom[0] = ti(IMM, 5'd0, 5'd0, 16'h1234);
        rom[1] = ti(ADDI, 5'd4, 5'd0, 16'h5678);
        rom[2] = ti(ADDI, 5'd5, 5'd0, 16'hFFFF);
        do_reset();
        cyc(6);
        nvec++; if (dut.rf_q[4] !== 32'h1234_5678) begin nerr++; $display("FAIL imm_r4 got=%h exp=12345678", dut.rf_q[4]); end
        nvec++; if (dut.rf_q[5] !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL imm_r5 got=%h exp=ffffffff", dut.rf_q[5]); end
    endtask

    task automatic test_mem();
        clear_rom();
        rom[0] = ti(ADDI, 5'd3, 5'd0, 16'd2);
        rom[1] = ti(SWI, 5'd3, 5'd0, 16'd8);
        rom[2] = ti(LWI, 5'd6, 5'd0, 16'd8);
        do_reset();
        cyc(4);
        nvec++; if (dmem_req !== 1'b1) begin nerr++; $display("FAIL sw_req got=%b exp=1", dmem_req); end
        nvec++; if (dmem_we !== 1'b1) begin nerr++; $display("FAIL sw_we got=%b exp=1", dmem_we); end
        nvec++; if (dmem_addr !== 12'd2) begin nerr++; $display("FAIL sw_addr got=%h exp=2", dmem_addr); end
        nvec++; if (dmem_wdata !== 32'd2) begin nerr++; $display("FAIL sw_wdata got=%h exp=2", dmem_wdata); end
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            nvec++; if (dmem_req !== 1'b1) begin nerr++; $display("FAIL sw_wait_req%0d got=%b exp=1", i, dmem_req); end
            nvec++; if (imem_addr !== 10'd1) begin nerr++; $display("FAIL sw_wait_pc%0d got=%h exp=1", i, imem_addr); end
        end
        mem_w = dmem_wdata;
        dmem_ack = 1'b1;
        cyc(1);
        dmem_ack = 1'b0;
        nvec++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL sw_drop got=%b exp=0", dmem_req); end
        nvec++; if (imem_addr !== 10'd2) begin nerr++; $display("FAIL sw_pc got=%h exp=2", imem_addr); end
        cyc(2);
        nvec++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin nerr++; $display("FAIL lw_req got=%b%b exp=10", dmem_req, dmem_we); end
        nvec++; if (dmem_addr !== 12'd2) begin nerr++; $display("FAIL lw_addr got=%h exp=2", dmem_addr); end
        cyc(1);
        nvec++; if (imem_addr !== 10'd2) begin nerr++; $display("FAIL lw_wait_pc got=%h exp=2", imem_addr); end
        dmem_rdata = mem_w;
        dmem_ack = 1'b1;
        cyc(1);
        dmem_ack = 1'b0;
        nvec++; if (dut.rf_q[6] !== 32'd2) begin nerr++; $display("FAIL lw_r6 got=%h exp=2", dut.rf_q[6]); end
        nvec++; if (imem_addr !== 10'd3) begin nerr++; $display("FAIL lw_pc got=%h exp=3", imem_addr); end
    endtask

    task automatic test_reset_mid_mem();
        clear_rom();
        rom[0] = ti(ADDI, 5'd3, 5'd0, 16'd2);
        rom[1] = ti(SWI, 5'd3, 5'd0, 16'd8);
        do_reset();
        cyc(4);
        nvec++; if (dmem_req !== 1'b1) begin nerr++; $display("FAIL mid_req got=%b exp=1", dmem_req); end
        reset = 1'b0;
        #1;
        nvec++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin nerr++; $display("FAIL mid_drop got=%b%b exp=00", dmem_req, dmem_we); end
    endtask

    task automatic test_io();
        clear_rom();
        in_port = 16'h00A5;
        rom[0] = ti(IMM, 5'd0, 5'd0, 16'h1234);
        rom[1] = ti(ADDI, 5'd4, 5'd0, 16'h5678);
        rom[2] = ti(SWI, 5'd4, 5'd0, 16'h4004);
        rom[3] = ti(ADDI, 5'd10, 5'd0, 16'd7);
        rom[4] = ti(LWI, 5'd10, 5'd0, 16'h4008);
        rom[5] = ti(LWI, 5'd9, 5'd0, 16'h4000);
        rom[6] = ti(SWI, 5'd4, 5'd0, 16'h4008);
        do_reset();
        cyc(6);
        nvec++; if (out_port !== 16'h7800) begin nerr++; $display("FAIL io_out1 got=%h exp=7800", out_port); end
        nvec++; if (dmem_req !== 1'b0) begin nerr++; $display("FAIL io_noreq got=%b exp=0", dmem_req); end
        cyc(2);
        nvec++; if (dut.rf_q[10] !== 32'd7) begin nerr++; $display("FAIL io_pre got=%h exp=7", dut.rf_q[10]); end
        cyc(2);
        nvec++; if (dut.rf_q[10] !== 32'd0) begin nerr++; $display("FAIL io_ld_oob got=%h exp=0", dut.rf_q[10]); end
        cyc(2);
        nvec++; if (dut.rf_q[9] !== 32'h0000_00A5) begin nerr++; $display("FAIL io_ld0 got=%h exp=000000a5", dut.rf_q[9]); end
        cyc(2);
        nvec++; if (out_port !== 16'h7800) begin nerr++; $display("FAIL io_st_oob got=%h exp=7800", out_port); end
        nvec++; if (imem_addr !== 10'd7) begin nerr++; $display("FAIL io_cpi got=%h exp=7", imem_addr); end
    endtask

    task automatic test_branch();
        clear_rom();
        rom[1]  = ti(BRI, 5'd11, 5'b11100, 16'h0040);
        rom[2]  = ti(ADDI, 5'd7, 5'd0, 16'd1);
        rom[3]  = ti(ADDI, 5'd12, 5'd0, 16'd9);
        rom[16] = ti(ADDI, 5'd13, 5'd0, 16'd3);
        do_reset();
        cyc(4);
        nvec++; if (imem_addr !== 10'd2) begin nerr++; $display("FAIL br_slot_pc got=%h exp=2", imem_addr); end
        cyc(2);
        nvec++; if (imem_addr !== 10'd16) begin nerr++; $display("FAIL br_target got=%h exp=10", imem_addr); end
        nvec++; if (dut.rf_q[7] !== 32'd1) begin nerr++; $display("FAIL br_slot_r7 got=%h exp=1", dut.rf_q[7]); end
        nvec++; if (dut.rf_q[11] !== 32'd4) begin nerr++; $display("FAIL br_link got=%h exp=4", dut.rf_q[11]); end
        cyc(2);
        nvec++; if (dut.rf_q[13] !== 32'd3) begin nerr++; $display("FAIL br_tgt_r13 got=%h exp=3", dut.rf_q[13]); end
        nvec++; if (dut.rf_q[12] !== 32'd0) begin nerr++; $display("FAIL br_skip got=%h exp=0", dut.rf_q[12]); end
    endtask

    task automatic test_delay_trap();
        clear_rom();
        rom[0] = ti(BRI, 5'd0, 5'b11000, 16'h0040);
        rom[1] = ti(BRI, 5'd0, 5'b11000, 16'h0080);
        do_reset();
        cyc(2);
        nvec++; if (trap !== 1'b0) begin nerr++; $display("FAIL dtrap_early got=%b exp=0", trap); end
        cyc(2);
        nvec++; if (trap !== 1'b1) begin nerr++; $display("FAIL dtrap_set got=%b exp=1", trap); end
        cyc(5);
        nvec++; if (trap !== 1'b1) begin nerr++; $display("FAIL dtrap_hold got=%b exp=1", trap); end
        nvec++; if (imem_addr !== 10'd1) begin nerr++; $display("FAIL dtrap_pc got=%h exp=1", imem_addr); end
    endtask

    task automatic test_illegal_reset();
        clear_rom();
        rom[0] = ti(ADDI, 5'd1, 5'd0, 16'hFFFF);
        rom[1] = ti(ADDI, 5'd2, 5'd1, 16'd1);
        rom[2] = ti(SWI, 5'd1, 5'd0, 16'h4000);
        rom[3] = 32'hFC00_0000;
        do_reset();
        cyc(6);
        nvec++; if (out_port !== 16'h00FF) begin nerr++; $display("FAIL ill_out got=%h exp=00ff", out_port); end
        cyc(2);
        nvec++; if (trap !== 1'b1) begin nerr++; $display("FAIL ill_trap got=%b exp=1", trap); end
        cyc(4);
        nvec++; if (imem_addr !== 10'd3 || trap !== 1'b1) begin nerr++; $display("FAIL ill_hold got=%h/%b exp=3/1", imem_addr, trap); end
        reset = 1'b0;
        #1;
        nvec++; if (trap !== 1'b0) begin nerr++; $display("FAIL ill_rst_trap got=%b exp=0", trap); end
        nvec++; if (out_port !== 16'd0) begin nerr++; $display("FAIL ill_rst_out got=%h exp=0", out_port); end
        nvec++; if (imem_addr !== 10'd0) begin nerr++; $display("FAIL ill_rst_pc got=%h exp=0", imem_addr); end
        for (int i = 0; i < 32; i++) begin
            nvec++; if (dut.rf_q[i] !== 32'd0) begin nerr++; $display("FAIL ill_rst_r%0d got=%h exp=0", i, dut.rf_q[i]); end
        end
        clear_rom();
        rom[0] = tr(ADDC, 5'd8, 5'd0, 5'd0);
        rom[1] = ti(ADDI, 5'd9, 5'd0, 16'd1);
        @(negedge clk);
        reset = 1'b1;
        cyc(2);
        nvec++; if (dut.rf_q[8] !== 32'd0) begin nerr++; $display("FAIL ill_rst_c got=%h exp=0", dut.rf_q[8]); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_mem();
        test_reset_mid_mem();
        test_io();
        test_branch();
        test_delay_trap();
        test_illegal_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
